// File: rtl/pc_jump_unit.sv
// pc_jump_unit: fetch program counter with jump redirect and squash recovery.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   stall        hold the PC this cycle
//   jump_valid   jump_offset/jump_base carry a taken jump this cycle
//   jump_offset  13-bit byte offset, already shifted left by 1
//   jump_base    PC+2 of the jump instruction
//   pc_out       current fetch address (registered)
//   pc_plus2     pc_out + 2, wrapping
//   flush        squash fetch/decode (registered)
//   fetch_valid  pc_out is a live, non-squashed fetch
//
// After a taken jump, flush stays high for FLUSH_CYCLES cycles.
// Jumps arriving while squashing belong to dead instructions and are dropped.
module pc_jump_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [12:0] jump_offset,
  input  logic [15:0] jump_base,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        flush,
  output logic        fetch_valid
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [15:0] pc_n;
  logic        flush_n;
  logic [15:0] target;

  // Region bits come from the jump's own PC+2; bit 0 is forced low so
  // an odd offset can never produce a misaligned fetch.
  assign target      = {jump_base[15:13], jump_offset[12:1], 1'b0};
  assign pc_plus2    = pc_out + 16'd2;
  assign fetch_valid = ~flush & ~stall & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= RUN;
      cnt    <= 3'd0;
      pc_out <= RESET_PC;
      flush  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pc_out <= pc_n;
      flush  <= flush_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc_out;
    flush_n = flush;
    unique case (state)
      RUN: begin
        if (jump_valid) begin
          // Jump wins over stall: the redirect must not be lost.
          pc_n    = target;
          flush_n = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = (FLUSH_CYCLES > 1) ? SQUASH : RUN;
        end else begin
          flush_n = 1'b0;
          if (!stall) pc_n = pc_plus2;
        end
      end
      SQUASH: begin
        // Counter runs independent of stall; PC still honours stall.
        if (!stall) pc_n = pc_plus2;
        if (cnt == 3'd0) begin
          state_n = RUN;
          flush_n = 1'b0;
        end else begin
          cnt_n   = cnt - 3'd1;
          flush_n = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_jump_unit.sv
// Bench for pc_jump_unit: two instances (default params, and RESET_PC=1234 /
// FLUSH_CYCLES=3) driven with the same directed and random stimulus and
// compared against a cycle-count reference model.
module tb_pc_jump_unit;

  logic        clock = 1'b0;
  logic        reset, stall, jump_valid;
  logic [12:0] jump_offset;
  logic [15:0] jump_base;
  logic [15:0] pc_a, p2_a, pc_b, p2_b;
  logic        fl_a, fv_a, fl_b, fv_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pc_jump_unit u_dut (
    .clock(clock), .reset(reset), .stall(stall), .jump_valid(jump_valid),
    .jump_offset(jump_offset), .jump_base(jump_base),
    .pc_out(pc_a), .pc_plus2(p2_a), .flush(fl_a), .fetch_valid(fv_a)
  );

  pc_jump_unit #(.RESET_PC(16'h1234), .FLUSH_CYCLES(3)) u_dut3 (
    .clock(clock), .reset(reset), .stall(stall), .jump_valid(jump_valid),
    .jump_offset(jump_offset), .jump_base(jump_base),
    .pc_out(pc_b), .pc_plus2(p2_b), .flush(fl_b), .fetch_valid(fv_b)
  );

  // Reference model: pc plus number of flushed cycles still to show.
  logic [15:0] m_pc  [2];
  int          m_rem [2];
  int          m_fc  [2] = '{2, 3};
  logic [15:0] m_rpc [2] = '{16'h0000, 16'h1234};
  bit          m_ok = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_model();
    logic [15:0] pc [2];
    logic [15:0] p2 [2];
    logic        fl [2];
    logic        fv [2];
    pc = '{pc_a, pc_b}; p2 = '{p2_a, p2_b};
    fl = '{fl_a, fl_b}; fv = '{fv_a, fv_b};
    for (int i = 0; i < 2; i++) begin
      logic mf;
      mf = (m_rem[i] > 0);
      chk($sformatf("pc%0d", i),     {16'h0, pc[i]}, {16'h0, m_pc[i]});
      chk($sformatf("plus2_%0d", i), {16'h0, p2[i]}, {16'h0, 16'(m_pc[i] + 16'd2)});
      chk($sformatf("flush%0d", i),  {31'h0, fl[i]}, {31'h0, mf});
      chk($sformatf("fv%0d", i),     {31'h0, fv[i]}, {31'h0, (!mf && !stall && !reset)});
    end
  endtask

  // Called at a negedge: drive, check outputs, clock once, advance model.
  task automatic step(input logic r, input logic s, input logic jv,
                      input logic [12:0] off, input logic [15:0] base);
    reset = r; stall = s; jump_valid = jv; jump_offset = off; jump_base = base;
    #1;
    if (m_ok) cmp_model();
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      logic [15:0] tgt;
      tgt = (base & 16'hE000) | ({3'b000, off} & 16'h1FFE);
      if (r) begin
        m_pc[i] = m_rpc[i]; m_rem[i] = 0;
      end else if (jv && (m_rem[i] == 0 || m_fc[i] == 1)) begin
        m_pc[i] = tgt; m_rem[i] = m_fc[i];
      end else begin
        if (m_rem[i] > 0) m_rem[i]--;
        if (!s) m_pc[i] = m_pc[i] + 16'd2;
      end
    end
    if (r) m_ok = 1'b1;
    @(negedge clock);
  endtask

  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) step(1'b0, s, 1'b0, 13'h0, 16'h0);
  endtask

  // Constant expectations on the default instance, taken from worked examples.
  task automatic expect_a(input string tag, input logic [15:0] pc, input logic fl);
    chk({tag, "_pc"},    {16'h0, pc_a}, {16'h0, pc});
    chk({tag, "_flush"}, {31'h0, fl_a}, {31'h0, fl});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; jump_valid = 1'b0;
    jump_offset = '0; jump_base = '0;
    @(negedge clock);
    step(1'b1, 1'b1, 1'b1, 13'h1FFF, 16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 13'h0, 16'h0);
    expect_a("rst", 16'h0000, 1'b0);
    chk("rst_b_pc", {16'h0, pc_b}, 32'h1234);

    // Sequential run
    for (int i = 1; i <= 4; i++) begin
      run(1, 1'b0);
      expect_a($sformatf("seq%0d", i), 16'(2 * i), 1'b0);
    end

    // Jump with a dropped jump during squash
    step(1'b0, 1'b0, 1'b1, 13'b1011100011110, 16'h4006);
    expect_a("jmp0", 16'h571E, 1'b1);
    step(1'b0, 1'b0, 1'b1, 13'h0444, 16'h8000);
    expect_a("jmp1", 16'h5720, 1'b1);
    run(1, 1'b0);
    expect_a("jmp2", 16'h5722, 1'b0);
    run(1, 1'b0);
    expect_a("jmp3", 16'h5724, 1'b0);
    run(3, 1'b0);

    // Jump under stall, odd offset bit
    step(1'b0, 1'b1, 1'b1, 13'h0011, 16'hE000);
    expect_a("stjmp", 16'hE010, 1'b1);
    run(4, 1'b0);

    // Wrap: jump to FFFC while stalled, then run
    step(1'b0, 1'b1, 1'b1, 13'h1FFC, 16'hE000);
    run(3, 1'b1);
    expect_a("wrap0", 16'hFFFC, 1'b0);
    run(1, 1'b0); expect_a("wrap1", 16'hFFFE, 1'b0);
    run(1, 1'b0); expect_a("wrap2", 16'h0000, 1'b0);
    run(1, 1'b0); expect_a("wrap3", 16'h0002, 1'b0);

    // Stall hold at 0010
    step(1'b1, 1'b0, 1'b0, 13'h0, 16'h0);
    run(8, 1'b0);
    expect_a("hold0", 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 13'h0, 16'h0);
      expect_a($sformatf("hold%0d", i + 1), 16'h0010, 1'b0);
    end
    run(1, 1'b0);
    expect_a("rel", 16'h0012, 1'b0);

    // Reset on the first squash cycle
    step(1'b0, 1'b0, 1'b1, 13'h0100, 16'h2000);
    expect_a("rsq0", 16'h2100, 1'b1);
    step(1'b1, 1'b0, 1'b0, 13'h0, 16'h0);
    expect_a("rsq1", 16'h0000, 1'b0);
    run(1, 1'b0);
    expect_a("rsq2", 16'h0002, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), 13'($urandom), 16'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 13'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
